// File: rtl/mouse_cursor_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mouse_cursor_gen
// Description : Arrow-cursor overlay for a 640x480 VGA scan, with frame-latched
//               position, button synchroniser/click pulse, menu hover flags and
//               an inactivity auto-hide.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_cursor_gen #(
    parameter int          FRAME_LINE  = 480,
    parameter int          IDLE_FRAMES = 300,
    parameter logic [11:0] FILL_COLOR  = 12'hFFF,
    parameter logic [11:0] PRESS_COLOR = 12'hF00,
    parameter logic [39:0] START_BOX   = {10'd240, 10'd200, 10'd399, 10'd249},
    parameter logic [39:0] CONNECT_BOX = {10'd240, 10'd280, 10'd399, 10'd329},
    parameter logic [39:0] RETURN_BOX  = {10'd240, 10'd360, 10'd399, 10'd409}
) (
    input  logic        clka,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    input  logic        MOUSE_LEFT,
    input  logic [1:0]  state,
    output logic        enable_mouse_display,
    output logic [11:0] mouse_pixel,
    output logic        mouse_on_start_button,
    output logic        mouse_on_connect_button,
    output logic        mouse_on_return_button,
    output logic        mouse_click
);

    localparam logic [1:0] SMENU = 2'd0;
    localparam logic [1:0] SOVER = 2'd2;
    localparam logic [9:0] c_frame_line  = FRAME_LINE[9:0];
    localparam logic [8:0] c_idle_frames = IDLE_FRAMES[8:0];
    localparam logic [9:0] c_max_x = 10'd639;
    localparam logic [9:0] c_max_y = 10'd479;

    // Box layout is {x0, y0, x1, y1}, all bounds inclusive.
    function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                    input logic [39:0] b);
        return (x >= b[39:30]) && (x <= b[19:10]) &&
               (y >= b[29:20]) && (y <= b[9:0]);
    endfunction

    logic       left_s1_q, left_s1_d;
    logic       left_s2_q, left_s2_d;
    logic       pressed_prev_q, pressed_prev_d;
    logic       click_q, click_d;
    logic       strobe_dly_q, strobe_dly_d;
    logic [9:0] cur_x_q, cur_x_d;
    logic [9:0] cur_y_q, cur_y_d;
    logic [8:0] idle_q, idle_d;
    logic       on_start_q, on_start_d;
    logic       on_connect_q, on_connect_d;
    logic       on_return_q, on_return_d;

    logic       w_strobe;
    logic       w_pressed;
    logic [9:0] w_clamp_x;
    logic [9:0] w_clamp_y;

    assign w_pressed = left_s2_q;
    assign w_strobe  = (h_cnt == 10'd0) && (v_cnt == c_frame_line);
    assign w_clamp_x = (mouse_x > c_max_x) ? c_max_x : mouse_x;
    assign w_clamp_y = (mouse_y > c_max_y) ? c_max_y : mouse_y;

    always_comb begin
        left_s1_d      = MOUSE_LEFT;
        left_s2_d      = left_s1_q;
        pressed_prev_d = left_s2_q;
        click_d        = left_s2_q & ~pressed_prev_q;
        strobe_dly_d   = w_strobe;
        cur_x_d        = cur_x_q;
        cur_y_d        = cur_y_q;
        idle_d         = idle_q;
        on_start_d     = on_start_q;
        on_connect_d   = on_connect_q;
        on_return_d    = on_return_q;

        // The currently latched position doubles as the "previous" one for
        // the idle comparison, since it only ever changes on a strobe.
        if (w_strobe) begin
            cur_x_d = w_clamp_x;
            cur_y_d = w_clamp_y;
            if ((w_clamp_x != cur_x_q) || (w_clamp_y != cur_y_q) || w_pressed)
                idle_d = 9'd0;
            else if (idle_q != c_idle_frames)
                idle_d = idle_q + 9'd1;
        end

        if (strobe_dly_q) begin
            on_start_d   = (state == SMENU) && in_box(cur_x_q, cur_y_q, START_BOX);
            on_connect_d = (state == SMENU) && in_box(cur_x_q, cur_y_q, CONNECT_BOX);
            on_return_d  = (state == SOVER) && in_box(cur_x_q, cur_y_q, RETURN_BOX);
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            left_s1_q      <= 1'b0;
            left_s2_q      <= 1'b0;
            pressed_prev_q <= 1'b0;
            click_q        <= 1'b0;
            strobe_dly_q   <= 1'b0;
            cur_x_q        <= 10'd320;
            cur_y_q        <= 10'd240;
            idle_q         <= 9'd0;
            on_start_q     <= 1'b0;
            on_connect_q   <= 1'b0;
            on_return_q    <= 1'b0;
        end else begin
            left_s1_q      <= left_s1_d;
            left_s2_q      <= left_s2_d;
            pressed_prev_q <= pressed_prev_d;
            click_q        <= click_d;
            strobe_dly_q   <= strobe_dly_d;
            cur_x_q        <= cur_x_d;
            cur_y_q        <= cur_y_d;
            idle_q         <= idle_d;
            on_start_q     <= on_start_d;
            on_connect_q   <= on_connect_d;
            on_return_q    <= on_return_d;
        end
    end

    // Pixel path is purely combinational on the live scan position.
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_inside;
    logic       w_border;
    logic       w_hidden;

    assign w_dx     = h_cnt - cur_x_q;
    assign w_dy     = v_cnt - cur_y_q;
    assign w_hidden = (idle_q == c_idle_frames);
    assign w_inside = (h_cnt >= cur_x_q) && (v_cnt >= cur_y_q) &&
                      (w_dx < 10'd12) && (w_dy < 10'd12) && (w_dx <= w_dy) &&
                      (h_cnt <= c_max_x) && (v_cnt <= c_max_y);
    assign w_border = (w_dx == 10'd0) || (w_dx == w_dy) || (w_dy == 10'd11);

    always_comb begin
        enable_mouse_display = w_inside && !w_hidden;
        mouse_pixel          = 12'h000;
        if (enable_mouse_display && !w_border)
            mouse_pixel = w_pressed ? PRESS_COLOR : FILL_COLOR;
    end

    assign mouse_on_start_button   = on_start_q;
    assign mouse_on_connect_button = on_connect_q;
    assign mouse_on_return_button  = on_return_q;
    assign mouse_click             = click_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_cursor_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mouse_cursor_gen
// Description : Directed self-checking bench for mouse_cursor_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_cursor_gen;

    logic        clka = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt, mouse_x, mouse_y;
    logic        MOUSE_LEFT;
    logic [1:0]  state;
    logic        enable_mouse_display;
    logic [11:0] mouse_pixel;
    logic        on_start, on_connect, on_return, mouse_click;

    int checks = 0;
    int errors = 0;

    mouse_cursor_gen dut (
        .clka                    (clka),
        .rst                     (rst),
        .h_cnt                   (h_cnt),
        .v_cnt                   (v_cnt),
        .mouse_x                 (mouse_x),
        .mouse_y                 (mouse_y),
        .MOUSE_LEFT              (MOUSE_LEFT),
        .state                   (state),
        .enable_mouse_display    (enable_mouse_display),
        .mouse_pixel             (mouse_pixel),
        .mouse_on_start_button   (on_start),
        .mouse_on_connect_button (on_connect),
        .mouse_on_return_button  (on_return),
        .mouse_click             (mouse_click)
    );

    always #5 clka = ~clka;

    task automatic cycle();
        @(posedge clka);
        #1;
    endtask

    task automatic scan(input logic [9:0] h, input logic [9:0] v);
        h_cnt = h;
        v_cnt = v;
        #1;
    endtask

    // One strobe cycle, then park the scan on a non-strobe position.
    task automatic strobe();
        cycle();
        h_cnt = 10'd0;
        v_cnt = 10'd480;
        cycle();
        h_cnt = 10'd1;
        v_cnt = 10'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0; MOUSE_LEFT = 1'b0; state = 2'd1;
        mouse_x = 10'd0; mouse_y = 10'd0; h_cnt = 10'd1; v_cnt = 10'd0;
        repeat (3) cycle();
        checks++;
        if (mouse_click !== 1'b0 || on_start !== 1'b0 || on_connect !== 1'b0 || on_return !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: click=%b flags=%b%b%b expected 0 000", mouse_click, on_start, on_connect, on_return);
        end
        scan(10'd320, 10'd240);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL reset_border: en=%b px=%h expected 1 000", enable_mouse_display, mouse_pixel);
        end
        scan(10'd321, 10'd245);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'hFFF) begin
            errors++;
            $display("FAIL reset_fill: en=%b px=%h expected 1 fff", enable_mouse_display, mouse_pixel);
        end
        scan(10'd319, 10'd240);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL reset_left_of_cursor: en=%b expected 0", enable_mouse_display);
        end
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_latch();
        mouse_x = 10'd100; mouse_y = 10'd50;
        strobe();
        scan(10'd100, 10'd50);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL latch_border: en=%b px=%h expected 1 000", enable_mouse_display, mouse_pixel);
        end
        scan(10'd101, 10'd55);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'hFFF) begin
            errors++;
            $display("FAIL latch_fill: en=%b px=%h expected 1 fff", enable_mouse_display, mouse_pixel);
        end
        scan(10'd105, 10'd50);
        checks++;
        if (enable_mouse_display !== 1'b0 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL latch_outside_dx_gt_dy: en=%b px=%h expected 0 000", enable_mouse_display, mouse_pixel);
        end
        scan(10'd100, 10'd61);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL latch_bottom_row: en=%b px=%h expected 1 000", enable_mouse_display, mouse_pixel);
        end
        scan(10'd100, 10'd62);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL latch_below_cursor: en=%b expected 0", enable_mouse_display);
        end
        scan(10'd99, 10'd55);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL latch_no_wrap: en=%b expected 0", enable_mouse_display);
        end
    endtask

    task automatic test_hover();
        mouse_x = 10'd300; mouse_y = 10'd220; state = 2'd0;
        scan(10'd100, 10'd50);
        checks++;
        if (enable_mouse_display !== 1'b1) begin
            errors++;
            $display("FAIL hover_hold_old_pos: en=%b expected 1", enable_mouse_display);
        end
        scan(10'd300, 10'd220);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL hover_new_pos_early: en=%b expected 0", enable_mouse_display);
        end
        strobe();
        checks++;
        if (on_start !== 1'b0) begin
            errors++;
            $display("FAIL hover_start_at_strobe: got %b expected 0", on_start);
        end
        cycle();
        checks++;
        if (on_start !== 1'b1 || on_connect !== 1'b0 || on_return !== 1'b0) begin
            errors++;
            $display("FAIL hover_start: flags=%b%b%b expected 100", on_start, on_connect, on_return);
        end
        scan(10'd300, 10'd220);
        checks++;
        if (enable_mouse_display !== 1'b1) begin
            errors++;
            $display("FAIL hover_new_pos_drawn: en=%b expected 1", enable_mouse_display);
        end
        mouse_x = 10'd250; mouse_y = 10'd300;
        strobe(); cycle();
        checks++;
        if (on_start !== 1'b0 || on_connect !== 1'b1 || on_return !== 1'b0) begin
            errors++;
            $display("FAIL hover_connect: flags=%b%b%b expected 010", on_start, on_connect, on_return);
        end
        state = 2'd1;
        strobe(); cycle();
        checks++;
        if (on_connect !== 1'b0) begin
            errors++;
            $display("FAIL hover_game_state: connect=%b expected 0", on_connect);
        end
        state = 2'd2; mouse_x = 10'd300; mouse_y = 10'd380;
        strobe(); cycle();
        checks++;
        if (on_start !== 1'b0 || on_connect !== 1'b0 || on_return !== 1'b1) begin
            errors++;
            $display("FAIL hover_return: flags=%b%b%b expected 001", on_start, on_connect, on_return);
        end
    endtask

    task automatic test_click();
        int pulses = 0;
        h_cnt = 10'd301; v_cnt = 10'd385;
        MOUSE_LEFT = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            checks++;
            if (mouse_click !== (i == 3)) begin
                errors++;
                $display("FAIL click_pulse cycle %0d: got %b expected %b", i, mouse_click, (i == 3));
            end
            if (mouse_click === 1'b1) pulses++;
            if (i == 5) begin
                checks++;
                if (mouse_pixel !== 12'hF00) begin
                    errors++;
                    $display("FAIL click_press_color: px=%h expected f00", mouse_pixel);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL click_pulse_count: got %0d expected 1", pulses);
        end
        MOUSE_LEFT = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            checks++;
            if (mouse_click !== 1'b0) begin
                errors++;
                $display("FAIL click_release cycle %0d: got %b expected 0", i, mouse_click);
            end
        end
        checks++;
        if (mouse_pixel !== 12'hFFF) begin
            errors++;
            $display("FAIL click_release_color: px=%h expected fff", mouse_pixel);
        end
    endtask

    task automatic test_idle();
        state = 2'd1; mouse_x = 10'd300; mouse_y = 10'd380;
        repeat (299) strobe();
        scan(10'd300, 10'd380);
        checks++;
        if (enable_mouse_display !== 1'b1) begin
            errors++;
            $display("FAIL idle_visible_299: en=%b expected 1", enable_mouse_display);
        end
        strobe();
        scan(10'd300, 10'd380);
        checks++;
        if (enable_mouse_display !== 1'b0 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL idle_hidden_300: en=%b px=%h expected 0 000", enable_mouse_display, mouse_pixel);
        end
        repeat (2) strobe();
        scan(10'd301, 10'd385);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL idle_saturated: en=%b expected 0", enable_mouse_display);
        end
        mouse_x = 10'd301;
        scan(10'd300, 10'd380);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL idle_hidden_until_strobe: en=%b expected 0", enable_mouse_display);
        end
        strobe();
        scan(10'd301, 10'd380);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL idle_reappear: en=%b px=%h expected 1 000", enable_mouse_display, mouse_pixel);
        end
    endtask

    task automatic test_clip();
        mouse_x = 10'd1000; mouse_y = 10'd1000;
        strobe();
        scan(10'd639, 10'd479);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL clip_corner: en=%b px=%h expected 1 000", enable_mouse_display, mouse_pixel);
        end
        scan(10'd639, 10'd480);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL clip_below_screen: en=%b expected 0", enable_mouse_display);
        end
        scan(10'd640, 10'd480);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL clip_right_of_screen: en=%b expected 0", enable_mouse_display);
        end
        scan(10'd638, 10'd479);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL clip_left_column: en=%b expected 0", enable_mouse_display);
        end
    endtask

    task automatic test_async_reset();
        state = 2'd0; mouse_x = 10'd260; mouse_y = 10'd210;
        strobe(); cycle();
        checks++;
        if (on_start !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup_flag: got %b expected 1", on_start);
        end
        MOUSE_LEFT = 1'b1;
        repeat (3) cycle();
        checks++;
        if (mouse_click !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup_click: got %b expected 1", mouse_click);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mouse_click !== 1'b0 || on_start !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: click=%b start=%b expected 0 0", mouse_click, on_start);
        end
        scan(10'd320, 10'd240);
        checks++;
        if (enable_mouse_display !== 1'b1 || mouse_pixel !== 12'h000) begin
            errors++;
            $display("FAIL areset_cursor_home: en=%b px=%h expected 1 000", enable_mouse_display, mouse_pixel);
        end
        scan(10'd321, 10'd245);
        checks++;
        if (mouse_pixel !== 12'hFFF) begin
            errors++;
            $display("FAIL areset_fill_unpressed: px=%h expected fff", mouse_pixel);
        end
        MOUSE_LEFT = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (3) cycle();
        scan(10'd320, 10'd240);
        checks++;
        if (enable_mouse_display !== 1'b1) begin
            errors++;
            $display("FAIL areset_home_after_release: en=%b expected 1", enable_mouse_display);
        end
        scan(10'd260, 10'd210);
        checks++;
        if (enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL areset_old_pos_gone: en=%b expected 0", enable_mouse_display);
        end
    endtask

    initial begin
        test_reset();
        test_latch();
        test_hover();
        test_click();
        test_idle();
        test_clip();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
